// File: rtl/gtx_link_pkg.sv
// Shared GTX link definitions: control characters, header field layout, parser states.
// Used by the RX packet parser and the TX-side local packet builder.
package gtx_link_pkg;

  localparam logic [7:0] COMMA_CHAR     = 8'h3C;
  localparam logic [7:0] MPS_FAULT_CHAR = 8'h1C;
  localparam logic [7:0] SOP_CHAR       = 8'h5C;

  // Header word layout: {length[11:0], address[11:0], sop_char[7:0]}
  localparam int unsigned HdrCharLsb = 0;
  localparam int unsigned HdrCharMsb = 7;
  localparam int unsigned HdrAddrLsb = 8;
  localparam int unsigned HdrAddrMsb = 19;
  localparam int unsigned HdrLenLsb  = 20;
  localparam int unsigned HdrLenMsb  = 31;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTrailer
  } linkStateE;

endpackage

// File: rtl/rx_checksum_acc.sv
// Running 32-bit sum of packet body words, compared against the trailer word.
// Only instantiated when RX_CHECKSUM_EN is defined.
module rx_checksum_acc (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Clear,
  input  logic        Accumulate,
  input  logic [31:0] DataWord,
  input  logic [31:0] Trailer,
  output logic        Match
);

  logic [31:0] sumQ, sumD;

  // Next sum: clear on header accept, add each body word
  always_comb begin
    sumD = sumQ;
    if (Clear) begin
      sumD = '0;
    end else if (Accumulate) begin
      sumD = sumQ + DataWord;
    end
  end

  // Sum register
  always_ff @(posedge clk) begin
    if (Reset) begin
      sumQ <= '0;
    end else begin
      sumQ <= sumD;
    end
  end

  assign Match = (sumQ == Trailer);

endmodule

// File: rtl/gtx_rx_packet_parser.sv
// GTX RX packet parser: frames header/body(/trailer) packets out of the raw lane word
// stream, drops idle/comma words, and counts good packets and framing errors.
// Optional feature macro: RX_CHECKSUM_EN (adds trailer word and checksum check).
module gtx_rx_packet_parser
  import gtx_link_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 1024,
  parameter logic [7:0]  SOP_CHAR = gtx_link_pkg::SOP_CHAR
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] RxData,
  input  logic        RxCharIsK,
  output logic [31:0] LinkData,
  output logic        LinkDataValid,
  output logic        LinkStartOfPacket,
  output logic        LinkEndOfPacket,
  output logic [11:0] LinkPacketAddress,
  output logic [11:0] LinkPacketLength,
  output logic [15:0] LinkDataAddress,
  output logic [15:0] PacketCount,
  output logic [15:0] ErrorCount,
  output logic        ChecksumError,
  output logic        Busy
);

  linkStateE   stateQ, stateD;
  logic [11:0] addrQ, addrD, lenQ, lenD, idxQ, idxD;
  logic [31:0] dataQ, dataD;
  logic        validQ, validD, sopQ, sopD, eopQ, eopD;
  logic [15:0] dataAddrQ, dataAddrD;
  logic [15:0] pktQ, pktD, errQ, errD;
  logic        pktInc, errInc, accept;

  logic [7:0]  hdrChar;
  logic [11:0] hdrAddr, hdrLen;
  logic        isHeader, hdrLenOk, lastWord;

  assign hdrChar  = RxData[HdrCharMsb:HdrCharLsb];
  assign hdrAddr  = RxData[HdrAddrMsb:HdrAddrLsb];
  assign hdrLen   = RxData[HdrLenMsb:HdrLenLsb];
  assign isHeader = RxCharIsK && (hdrChar == SOP_CHAR);
  assign hdrLenOk = (hdrLen != 12'd0) && (hdrLen <= 12'(MAX_LEN));
  assign lastWord = (idxQ == lenQ - 12'd1);

`ifdef RX_CHECKSUM_EN
  logic cksClear, cksAcc, cksMatch, cksErrQ, cksErrD;

  rx_checksum_acc u_checksum (
    .clk        (clk),
    .Reset      (Reset),
    .Clear      (cksClear),
    .Accumulate (cksAcc),
    .DataWord   (RxData),
    .Trailer    (RxData),
    .Match      (cksMatch)
  );
`endif

  // Framing FSM next-state, output word and counter-increment decode
  always_comb begin
    stateD    = stateQ;
    addrD     = addrQ;
    lenD      = lenQ;
    idxD      = idxQ;
    dataD     = dataQ;
    validD    = 1'b0;
    sopD      = 1'b0;
    eopD      = 1'b0;
    dataAddrD = dataAddrQ;
    pktInc    = 1'b0;
    errInc    = 1'b0;
    accept    = 1'b0;
`ifdef RX_CHECKSUM_EN
    cksClear  = 1'b0;
    cksAcc    = 1'b0;
    cksErrD   = 1'b0;
`endif
    unique case (stateQ)
      StIdle: begin
        if (isHeader) begin
          if (hdrLenOk) accept = 1'b1;
          else          errInc = 1'b1;
        end
      end
      StData: begin
        if (RxCharIsK) begin
          // Abort; a valid header still starts the next packet this cycle
          errInc = 1'b1;
          stateD = StIdle;
          accept = isHeader && hdrLenOk;
        end else begin
          validD    = 1'b1;
          dataD     = RxData;
          sopD      = (idxQ == 12'd0);
          eopD      = lastWord;
          dataAddrD = {4'b0, addrQ} + {4'b0, idxQ};
          idxD      = idxQ + 12'd1;
`ifdef RX_CHECKSUM_EN
          cksAcc    = 1'b1;
          if (lastWord) stateD = StTrailer;
`else
          if (lastWord) begin
            stateD = StIdle;
            pktInc = 1'b1;
          end
`endif
        end
      end
`ifdef RX_CHECKSUM_EN
      StTrailer: begin
        if (RxCharIsK) begin
          errInc = 1'b1;
          stateD = StIdle;
          accept = isHeader && hdrLenOk;
        end else begin
          stateD = StIdle;
          if (cksMatch) begin
            pktInc = 1'b1;
          end else begin
            errInc  = 1'b1;
            cksErrD = 1'b1;
          end
        end
      end
`endif
      default: stateD = StIdle;
    endcase
    if (accept) begin
      addrD  = hdrAddr;
      lenD   = hdrLen;
      idxD   = 12'd0;
      stateD = StData;
`ifdef RX_CHECKSUM_EN
      cksClear = 1'b1;
`endif
    end
  end

  assign pktD = pktQ + {15'd0, pktInc};
  assign errD = (errInc && errQ != 16'hFFFF) ? errQ + 16'd1 : errQ;

  // State, field latches, registered outputs and counters
  always_ff @(posedge clk) begin
    if (Reset) begin
      stateQ    <= StIdle;
      addrQ     <= '0;
      lenQ      <= '0;
      idxQ      <= '0;
      dataQ     <= '0;
      validQ    <= 1'b0;
      sopQ      <= 1'b0;
      eopQ      <= 1'b0;
      dataAddrQ <= '0;
      pktQ      <= '0;
      errQ      <= '0;
    end else begin
      stateQ    <= stateD;
      addrQ     <= addrD;
      lenQ      <= lenD;
      idxQ      <= idxD;
      dataQ     <= dataD;
      validQ    <= validD;
      sopQ      <= sopD;
      eopQ      <= eopD;
      dataAddrQ <= dataAddrD;
      pktQ      <= pktD;
      errQ      <= errD;
    end
  end

`ifdef RX_CHECKSUM_EN
  // Checksum-mismatch pulse, one cycle after the trailer
  always_ff @(posedge clk) begin
    if (Reset) cksErrQ <= 1'b0;
    else       cksErrQ <= cksErrD;
  end
  assign ChecksumError = cksErrQ;
`else
  assign ChecksumError = 1'b0;
`endif

  assign LinkData          = dataQ;
  assign LinkDataValid     = validQ;
  assign LinkStartOfPacket = sopQ;
  assign LinkEndOfPacket   = eopQ;
  assign LinkPacketAddress = addrQ;
  assign LinkPacketLength  = lenQ;
  assign LinkDataAddress   = dataAddrQ;
  assign PacketCount       = pktQ;
  assign ErrorCount        = errQ;
  assign Busy              = (stateQ != StIdle);

endmodule

// File: tb/tb_gtx_rx_packet_parser.sv
// Bench for gtx_rx_packet_parser: directed steps plus random packet mixes, checked
// against a packet-level reference model. Honours RX_CHECKSUM_EN.
module tb_gtx_rx_packet_parser;

  localparam int unsigned TbMaxLen = 16;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] RxData;
  logic        RxCharIsK;
  logic [31:0] LinkData;
  logic        LinkDataValid, LinkStartOfPacket, LinkEndOfPacket;
  logic [11:0] LinkPacketAddress, LinkPacketLength;
  logic [15:0] LinkDataAddress, PacketCount, ErrorCount;
  logic        ChecksumError, Busy;

  always #5 clk = ~clk;

  gtx_rx_packet_parser #(
    .MAX_LEN  (TbMaxLen),
    .SOP_CHAR (gtx_link_pkg::SOP_CHAR)
  ) dut (
    .clk               (clk),
    .Reset             (Reset),
    .RxData            (RxData),
    .RxCharIsK         (RxCharIsK),
    .LinkData          (LinkData),
    .LinkDataValid     (LinkDataValid),
    .LinkStartOfPacket (LinkStartOfPacket),
    .LinkEndOfPacket   (LinkEndOfPacket),
    .LinkPacketAddress (LinkPacketAddress),
    .LinkPacketLength  (LinkPacketLength),
    .LinkDataAddress   (LinkDataAddress),
    .PacketCount       (PacketCount),
    .ErrorCount        (ErrorCount),
    .ChecksumError     (ChecksumError),
    .Busy              (Busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] addr;
    logic        sop;
    logic        eop;
  } outWordT;

  outWordT expQ[$];
  outWordT gotQ[$];
  int      checks = 0;
  int      failures = 0;
  int      expPkt = 0, expErr = 0, expCks = 0, gotCks = 0;

  // Collect every delivered word and checksum-error pulse away from the clock edge
  always @(negedge clk) begin
    if (LinkDataValid)
      gotQ.push_back({LinkData, LinkDataAddress, LinkStartOfPacket, LinkEndOfPacket});
    if (ChecksumError) gotCks++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic k, input logic [31:0] d);
    RxCharIsK = k;
    RxData    = d;
    @(negedge clk);
  endtask

  task automatic sendComma();
    send(1'b1, {24'h0, gtx_link_pkg::COMMA_CHAR});
  endtask

  task automatic expWord(input logic [31:0] d, input logic [11:0] a, input int i,
                         input logic s, input logic e);
    expQ.push_back({d, 16'({4'b0, a}) + 16'(i), s, e});
  endtask

  // Complete packet; body is 1..N when fixed, else random
  task automatic goodPkt(input logic [11:0] a, input logic [11:0] n, input logic fixed,
                         input logic corrupt);
    logic [31:0] sum = '0;
    logic [31:0] w;
    send(1'b1, {n, a, gtx_link_pkg::SOP_CHAR});
    for (int i = 0; i < int'(n); i++) begin
      w = fixed ? 32'(i + 1) : $urandom;
      sum += w;
      expWord(w, a, i, i == 0, i == int'(n) - 1);
      send(1'b0, w);
    end
`ifdef RX_CHECKSUM_EN
    if (corrupt) begin
      send(1'b0, sum + 32'd1);
      expErr++;
      expCks++;
    end else begin
      send(1'b0, sum);
      expPkt++;
    end
`else
    if (corrupt) sum = '0;
    expPkt++;
`endif
  endtask

  // Header plus k<N body words; ends with a comma unless the caller follows with a header
  task automatic abortPkt(input logic [11:0] a, input logic [11:0] n, input int k,
                          input logic byComma);
    logic [31:0] w;
    send(1'b1, {n, a, gtx_link_pkg::SOP_CHAR});
    for (int i = 0; i < k; i++) begin
      w = $urandom;
      expWord(w, a, i, i == 0, 1'b0);
      send(1'b0, w);
    end
    expErr++;
    if (byComma) begin
      sendComma();
      chk("busy_after_abort", 64'(Busy), 64'd0);
    end
  endtask

  task automatic badHdr(input logic [11:0] a, input logic [11:0] n);
    send(1'b1, {n, a, gtx_link_pkg::SOP_CHAR});
    expErr++;
  endtask

  task automatic idleNoise(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      case ($urandom_range(0, 2))
        0: send(1'b1, {$urandom_range(0, 16777215), gtx_link_pkg::COMMA_CHAR});
        1: send(1'b1, {24'h0, gtx_link_pkg::MPS_FAULT_CHAR});
        default: send(1'b0, $urandom);
      endcase
    end
  endtask

  task automatic checkStream(input string tag);
    sendComma();
    sendComma();
    chk({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++)
      chk({tag, "_word"}, 64'(gotQ[i]), 64'(expQ[i]));
    chk({tag, "_pkt"}, 64'(PacketCount), 64'(expPkt[15:0]));
    chk({tag, "_err"}, 64'(ErrorCount), 64'(expErr[15:0]));
    chk({tag, "_ckserr"}, 64'(gotCks), 64'(expCks));
    expQ.delete();
    gotQ.delete();
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_data"}, 64'(LinkData), 64'd0);
    chk({tag, "_strobes"},
        64'({LinkDataValid, LinkStartOfPacket, LinkEndOfPacket, ChecksumError, Busy}), 64'd0);
    chk({tag, "_paddr"}, 64'({LinkPacketAddress, LinkPacketLength}), 64'd0);
    chk({tag, "_daddr"}, 64'(LinkDataAddress), 64'd0);
    chk({tag, "_counts"}, 64'({PacketCount, ErrorCount}), 64'd0);
  endtask

  initial begin
    Reset     = 1'b1;
    RxCharIsK = 1'b1;
    RxData    = {24'h0, gtx_link_pkg::COMMA_CHAR};
    @(negedge clk);
    sendComma();
    checkAllZero("reset");
    Reset = 1'b0;
    sendComma();

    // Basic packet at 0x010, body 1..4
    goodPkt(12'h010, 12'd4, 1'b1, 1'b0);
    checkStream("basic");
    chk("pkt_addr", 64'(LinkPacketAddress), 64'h010);
    chk("pkt_len", 64'(LinkPacketLength), 64'd4);

    // Single-word packet and longest accepted packet
    goodPkt(12'h3A5, 12'd1, 1'b0, 1'b0);
    goodPkt(12'hFFE, 12'(TbMaxLen), 1'b0, 1'b0);
    checkStream("len_bounds");

    // Illegal lengths
    badHdr(12'h020, 12'd0);
    badHdr(12'h020, 12'(TbMaxLen + 1));
    checkStream("bad_len");

    // Comma aborts after two body words
    abortPkt(12'h040, 12'd4, 2, 1'b1);
    checkStream("abort_comma");

    // New header aborts the old packet and is delivered complete
    abortPkt(12'h050, 12'd6, 3, 1'b0);
    goodPkt(12'h060, 12'd5, 1'b0, 1'b0);
    checkStream("abort_header");

`ifdef RX_CHECKSUM_EN
    goodPkt(12'h070, 12'd4, 1'b1, 1'b1);
    checkStream("cks_bad");
`endif

    // Reset in the middle of a packet
    send(1'b1, {12'd6, 12'h080, gtx_link_pkg::SOP_CHAR});
    for (int i = 0; i < 2; i++) begin
      expWord(32'hA000 + 32'(i), 12'h080, i, i == 0, 1'b0);
      send(1'b0, 32'hA000 + 32'(i));
    end
    Reset = 1'b1;
    send(1'b0, 32'hA002);
    checkAllZero("mid_reset");
    Reset  = 1'b0;
    expPkt = 0;
    expErr = 0;
    expCks = 0;
    gotCks = 0;
    goodPkt(12'h090, 12'd3, 1'b0, 1'b0);
    checkStream("after_reset");

    // Random mix of traffic
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 4))
        0: idleNoise(int'($urandom_range(1, 4)));
        1: goodPkt(12'($urandom), 12'($urandom_range(1, TbMaxLen)), 1'b0,
                   $urandom_range(0, 3) == 0);
        2: badHdr(12'($urandom), ($urandom_range(0, 1) == 0) ? 12'd0
                                 : 12'($urandom_range(TbMaxLen + 1, 4095)));
        3: begin
          int n = int'($urandom_range(2, TbMaxLen));
          abortPkt(12'($urandom), 12'(n), int'($urandom_range(0, n - 1)), 1'b1);
        end
        default: begin
          int n = int'($urandom_range(2, TbMaxLen));
          abortPkt(12'($urandom), 12'(n), int'($urandom_range(0, n - 1)), 1'b0);
          goodPkt(12'($urandom), 12'($urandom_range(1, TbMaxLen)), 1'b0, 1'b0);
        end
      endcase
    end
    checkStream("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
